// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: ALU opcodes and FSM state encoding.
package mac_sequencer_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_MAC = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_sequencer_alu.sv
// Combinational ALU; MAC keeps the low 32 bits of a*b and adds the accumulator modulo 2^32.
module mac_sequencer_alu
    import mac_sequencer_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] accumulator,
    input  logic [3:0]  alu_control,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_MAC: result = (a * b) + accumulator;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mac_sequencer.sv
// Streams up to MAX_LEN operand pairs through the shared ALU as a multiply-accumulate job
// and presents the final accumulator with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; len/bias captured on start
// RUN   | accepting operand pairs, remaining counts down to the last beat
// DONE  | result held on the output until out_ready
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      bias,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_negative,
    output logic [LEN_W-1:0] out_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      acc;
    logic [31:0]      alu_result;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_eff;
    logic             beat;
    logic             last_beat;

    assign len_eff   = (len > LEN_MAX) ? LEN_MAX : len;
    assign beat      = in_ready & in_valid;
    assign last_beat = beat && (remaining == LEN_ONE);

    // The ALU is permanently in MAC mode; acc only captures its result on a beat.
    mac_sequencer_alu u_alu (
        .a           (in_a),
        .b           (in_b),
        .accumulator (acc),
        .alu_control (ALU_MAC),
        .result      (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len_eff == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (abort || out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = ~abort;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            remaining <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                acc       <= bias;
                count     <= '0;
                remaining <= len_eff;
            end
        end else if (abort) begin
            acc       <= '0;
            count     <= '0;
            remaining <= '0;
        end else if (beat) begin
            acc       <= alu_result;
            count     <= count + LEN_ONE;
            remaining <= remaining - LEN_ONE;
        end
    end

    assign out_result   = acc;
    assign out_zero     = (acc == '0);
    assign out_negative = acc[31];
    assign out_count    = count;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized job-level bench for mac_sequencer with an arithmetic reference model.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic [31:0] bias;
    logic        abort;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_negative;
    logic [4:0]  out_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] a_q [0:31];
    logic [31:0] b_q [0:31];

    always #5 clk = ~clk;

    mac_sequencer #(.MAX_LEN(16), .LEN_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .bias         (bias),
        .abort        (abort),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_negative (out_negative),
        .out_count    (out_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            a_q[i] = $urandom;
            b_q[i] = $urandom;
        end
    endtask

    // vprob < 0 toggles in_valid every other cycle; abort_at < 0 means no abort.
    task automatic run_job(input logic [31:0] bias_v, input int len_v, input int abort_at,
                           input int vprob, input int rdy_wait, input bit end_rst);
        int          len_eff;
        int          taken;
        int          cyc;
        bit          aborted;
        logic [31:0] sum;
        len_eff = (len_v > 16) ? 16 : len_v;
        taken   = 0;
        cyc     = 0;
        aborted = 1'b0;
        sum     = bias_v;

        @(negedge clk);
        start    = 1'b1;
        len      = 5'(len_v);
        bias     = bias_v;
        abort    = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        out_ready = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        check("idle_out_valid", out_valid, 0);

        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        while (taken < len_eff && !aborted) begin
            if (cyc > 300) begin
                check("beat_timeout", taken, len_eff);
                break;
            end
            in_valid = (vprob < 0) ? (cyc % 2 == 0) : (int'($urandom_range(0, 99)) < vprob);
            in_a     = a_q[taken];
            in_b     = b_q[taken];
            abort    = (abort_at >= 0) && (taken == abort_at);
            start    = 1'($urandom_range(0, 1));
            len      = 5'($urandom);
            bias     = $urandom;
            #1;
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, !abort);
            check("run_out_valid", out_valid, 0);
            if (abort) begin
                aborted = 1'b1;
            end else if (in_valid) begin
                sum = sum + in_a * in_b;
                taken++;
            end
            cyc++;
            @(negedge clk);
        end

        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        if (aborted) begin
            #1;
            check("abort_busy", busy, 0);
            check("abort_out_valid", out_valid, 0);
            return;
        end

        for (int i = 0; i <= rdy_wait; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            if (i == rdy_wait) begin
                out_ready = !end_rst;
                rst       = end_rst;
            end
            #1;
            check("done_valid", out_valid, 1);
            check("done_busy", busy, 1);
            check("done_in_ready", in_ready, 0);
            check("done_result", out_result, sum);
            check("done_count", out_count, len_eff);
            check("done_zero", out_zero, (sum == 0));
            check("done_negative", out_negative, sum[31]);
            @(negedge clk);
        end

        out_ready = 1'b0;
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("after_busy", busy, 0);
        check("after_out_valid", out_valid, 0);
        check("after_in_ready", in_ready, 0);
        if (end_rst) begin
            check("rst_zero", out_zero, 1);
            check("rst_negative", out_negative, 0);
            check("rst_result", out_result, 0);
            check("rst_count", out_count, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_zero", out_zero, 1);
        check("reset_negative", out_negative, 0);
        check("reset_result", out_result, 0);
        check("reset_count", out_count, 0);
        rst = 1'b0;

        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("idle_abort_busy", busy, 0);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("idle_abort_after", busy, 0);

        a_q[0] = 32'd2; b_q[0] = 32'd3;
        a_q[1] = 32'd4; b_q[1] = 32'd5;
        a_q[2] = 32'd1; b_q[2] = 32'd7;
        run_job(32'd10, 3, -1, 100, 0, 1'b0);

        run_job(32'd0, 0, -1, 100, 5, 1'b0);

        a_q[0] = 32'h8000_0000; b_q[0] = 32'd2;
        a_q[1] = 32'd1;         b_q[1] = 32'hFFFF_FFFF;
        run_job(32'd0, 2, -1, 100, 1, 1'b0);

        fill_random(4);
        run_job($urandom, 4, -1, -1, 0, 1'b0);

        fill_random(4);
        run_job($urandom, 4, 2, 100, 0, 1'b0);
        a_q[0] = 32'd3; b_q[0] = 32'd3;
        run_job(32'd5, 1, -1, 100, 0, 1'b0);

        fill_random(3);
        run_job($urandom, 3, -1, 100, 2, 1'b1);

        fill_random(20);
        run_job($urandom, 20, -1, 80, 1, 1'b0);

        for (int j = 0; j < 25; j++) begin
            int l;
            int ab;
            l  = $urandom_range(0, 20);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 16)) : -1;
            fill_random(20);
            run_job($urandom, l, ab, $urandom_range(30, 100), $urandom_range(0, 3),
                    1'($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum number of operand pairs per job.
REQ-002 Parameter LEN_W, default 5: width of the length and count fields, equal to clog2(MAX_LEN+1).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: job start strobe; sampled only in IDLE.
REQ-006 Port len, input, LEN_W: number of operand pairs in the job, 0..MAX_LEN; sampled with start.
REQ-007 Port bias, input, 32: initial accumulator value; sampled with start.
REQ-008 Port abort, input, 1: cancels the current job.
REQ-009 Port busy, output, 1: high in every state except IDLE.
REQ-010 Port in_valid, input, 1: operand pair valid.
REQ-011 Port in_ready, output, 1: sequencer accepts an operand pair.
REQ-012 Port in_a and in_b, input, 32 each: multiplicand and multiplier.
REQ-013 Port out_valid, output, 1: result available.
REQ-014 Port out_ready, input, 1: consumer accepts the result.
REQ-015 Port out_result, output, 32: final accumulator value.
REQ-016 Port out_zero and out_negative, output, 1 each: flags of out_result.
REQ-017 Port out_count, output, LEN_W: number of pairs consumed in the job.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 In IDLE, start=1 with len>0 SHALL:
- load acc <= bias
- load remaining <= len
- clear count
- go to RUN.
REQ-020 In IDLE, start=1 with len=0 SHALL load acc <= bias and go directly to DONE; out_count = 0.
REQ-021 If len > MAX_LEN at start, the sequencer SHALL clamp it to MAX_LEN.
REQ-022 in_ready SHALL equal 1 exactly when the state is RUN and abort=0.
REQ-023 Each RUN cycle with in_valid & in_ready (a beat) SHALL:
- drive ALU A=in_a, B=in_b, Accumulator=acc, ALUControl=4'b0100 (MAC)
- update acc <= ALU Result
- increment count
- decrement remaining.
REQ-024 The MAC SHALL keep the low 32 bits of the product plus acc and wrap modulo 2^32; no overflow is reported.
REQ-025 On the beat where remaining=1, the sequencer SHALL go to DONE in the next cycle; there is no idle gap between beats.
REQ-026 When the state is not RUN or there is no beat, the ALU SHALL be driven with ALUControl=4'b0100 and in_a/in_b unchanged, and acc SHALL hold.
REQ-027 In DONE:
- out_valid SHALL be 1
- out_result = acc, out_count = count
- out_zero = (acc==0), out_negative = acc[31].
REQ-028 All DONE outputs SHALL stay stable until out_valid & out_ready; then the sequencer SHALL go to IDLE in the next cycle.
REQ-029 out_valid SHALL be 0 in IDLE and RUN.
REQ-030 start SHALL be ignored in RUN and DONE.
REQ-031 abort=1 in RUN or DONE SHALL return the FSM to IDLE in the next cycle with acc cleared; no result is emitted and any beat in that cycle is dropped.
REQ-032 abort in IDLE SHALL have no effect; if start and abort are both 1 in IDLE, start SHALL win.

Reset
REQ-033 rst=1 SHALL, on the next clk edge and overriding all inputs:
- set state to IDLE
- clear acc, count and remaining
- force busy, in_ready and out_valid to 0, out_zero to 1, out_negative to 0.
REQ-034 rst asserted mid-job SHALL discard the job with no result emitted.

Structure
REQ-035 A shared package SHALL hold:
- the ALUControl opcode constants (ADD=0000, SUB=0001, AND=0010, OR=0011, MAC=0100, SLT=0101)
- the FSM state encoding.
REQ-036 mac_sequencer SHALL instantiate exactly one sub-module, the team's existing ALU, as the only arithmetic resource; there SHALL be no separate multiplier.
REQ-037 acc, count, remaining and state SHALL be the only registers; ALU flags SHALL NOT be registered separately.

Verification
REQ-038 len=3, bias=10, pairs (2,3),(4,5),(1,7) streamed back-to-back -> out_valid after 3 beats, out_result=43, out_count=3, out_zero=0.
REQ-039 len=0, bias=0 -> DONE on the cycle after start, out_result=0, out_zero=1; out_ready held 0 for 5 cycles -> outputs stable throughout.
REQ-040 len=2, bias=0, pairs (0x80000000,2),(1,0xFFFFFFFF) -> out_result=0xFFFFFFFF, out_negative=1 (wrap).
REQ-041 len=4, in_valid toggled every other cycle -> exactly 4 beats counted, correct sum, in_ready never high outside RUN.
REQ-042 abort after beat 2 of len=4 -> IDLE next cycle, no out_valid; a following job len=1, bias=5, pair (3,3) -> 14.
REQ-043 rst in DONE with out_ready=0 -> out_valid=0 next cycle; start in RUN -> ignored, result unchanged.
